// File: rtl/wave_capture.sv
// wave_capture: watches the strobed audio sample stream for a positive-going
// zero crossing, then records a window of 2^ADDR_WIDTH display samples into
// the half of a double-buffered waveform RAM the display is not reading.
// Finished halves are handed to the display once it reports idle.
module wave_capture #(
    parameter int unsigned ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  new_sample_ready,
    input  logic [15:0]           new_sample_in,
    input  logic                  wave_display_idle,
    output logic [ADDR_WIDTH:0]   write_address,
    output logic                  write_enable,
    output logic [7:0]            write_sample,
    output logic                  read_index
);

    typedef enum logic [1:0] {
        S_ARMED  = 2'd0,
        S_ACTIVE = 2'd1,
        S_WAIT   = 2'd2
    } state_t;

    state_t                  state_q;
    logic [15:0]             prev_q;
    logic [ADDR_WIDTH-1:0]   count_q;
    logic                    read_index_q;
    logic                    write_enable_q;
    logic [ADDR_WIDTH:0]     write_address_q;
    logic [7:0]              write_sample_q;

    logic                    crossing_d;
    logic [7:0]              display_d;
    logic                    last_index_d;

    // Crossing detection, offset-binary conversion and end-of-window flag.
    always_comb begin
        crossing_d   = prev_q[15] & ~new_sample_in[15];
        display_d    = {~new_sample_in[15], new_sample_in[14:8]};
        last_index_d = (count_q == '1);
    end

    // Capture FSM with registered RAM write port and buffer ownership.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= S_ARMED;
            prev_q          <= '0;
            count_q         <= '0;
            read_index_q    <= 1'b0;
            write_enable_q  <= 1'b0;
            write_address_q <= '0;
            write_sample_q  <= '0;
        end else begin
            write_enable_q <= 1'b0;

            if (new_sample_ready) begin
                prev_q <= new_sample_in;
            end

            unique case (state_q)
                S_ARMED: begin
                    if (new_sample_ready && crossing_d) begin
                        write_enable_q  <= 1'b1;
                        write_address_q <= {~read_index_q, {ADDR_WIDTH{1'b0}}};
                        write_sample_q  <= display_d;
                        count_q         <= {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
                        state_q         <= S_ACTIVE;
                    end
                end
                S_ACTIVE: begin
                    if (new_sample_ready) begin
                        write_enable_q  <= 1'b1;
                        write_address_q <= {~read_index_q, count_q};
                        write_sample_q  <= display_d;
                        count_q         <= count_q + 1'b1;
                        if (last_index_d) begin
                            state_q <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    // A strobe coinciding with idle only refreshes prev; it is
                    // deliberately not tested for a crossing.
                    if (wave_display_idle) begin
                        read_index_q <= ~read_index_q;
                        state_q      <= S_ARMED;
                    end
                end
                default: begin
                    state_q <= S_ARMED;
                end
            endcase
        end
    end

    assign write_enable  = write_enable_q;
    assign write_address = write_address_q;
    assign write_sample  = write_sample_q;
    assign read_index    = read_index_q;

endmodule

// File: tb/tb_wave_capture.sv
// Directed self-checking bench for wave_capture (ADDR_WIDTH = 8).
module tb_wave_capture;

    logic        clk;
    logic        reset;
    logic        new_sample_ready;
    logic [15:0] new_sample_in;
    logic        wave_display_idle;
    logic [8:0]  write_address;
    logic        write_enable;
    logic [7:0]  write_sample;
    logic        read_index;

    int unsigned checks;
    int unsigned errors;

    wave_capture #(.ADDR_WIDTH(8)) dut (
        .clk               (clk),
        .reset             (reset),
        .new_sample_ready  (new_sample_ready),
        .new_sample_in     (new_sample_in),
        .wave_display_idle (wave_display_idle),
        .write_address     (write_address),
        .write_enable      (write_enable),
        .write_sample      (write_sample),
        .read_index        (read_index)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        stb;
        logic [15:0] smp;
        logic        idle;
        logic        exp_we;
        logic [8:0]  exp_addr;
        logic [7:0]  exp_data;
        logic        exp_ri;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // Drive one cycle's inputs at negedge; return #1 after the following posedge.
    task automatic step(input logic stb, input logic [15:0] smp, input logic idle);
        @(negedge clk);
        new_sample_ready  = stb;
        new_sample_in     = smp;
        wave_display_idle = idle;
        @(posedge clk);
        #1;
        new_sample_ready  = 1'b0;
        wave_display_idle = 1'b0;
    endtask

    task automatic check_write(input string name, input logic [8:0] addr, input logic [7:0] data);
        check({name, ".we"}, 32'(write_enable), 32'd1);
        check({name, ".addr"}, 32'(write_address), 32'(addr));
        check({name, ".data"}, 32'(write_sample), 32'(data));
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset             = 1'b1;
        new_sample_ready  = 1'b0;
        wave_display_idle = 1'b0;
        @(posedge clk);
        #1;
        check("rst.we", 32'(write_enable), 32'd0);
        check("rst.addr", 32'(write_address), 32'd0);
        check("rst.data", 32'(write_sample), 32'd0);
        check("rst.ri", 32'(read_index), 32'd0);
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        logic [15:0] s;
        logic [7:0]  d;

        checks            = 0;
        errors            = 0;
        reset             = 1'b1;
        new_sample_ready  = 1'b0;
        new_sample_in     = '0;
        wave_display_idle = 1'b0;

        //            stb   sample    idle  we    addr     data   ri
        vecs[0]  = '{1'b1, 16'h0000, 1'b0, 1'b0, 9'h000, 8'h00, 1'b0}; // first post-reset zero
        vecs[1]  = '{1'b1, 16'h0005, 1'b0, 1'b0, 9'h000, 8'h00, 1'b0};
        vecs[2]  = '{1'b1, 16'h0100, 1'b0, 1'b0, 9'h000, 8'h00, 1'b0};
        vecs[3]  = '{1'b1, 16'h7FFF, 1'b0, 1'b0, 9'h000, 8'h00, 1'b0};
        vecs[4]  = '{1'b0, 16'h8000, 1'b0, 1'b0, 9'h000, 8'h00, 1'b0}; // unstrobed, ignored
        vecs[5]  = '{1'b1, 16'hFFF0, 1'b0, 1'b0, 9'h000, 8'h00, 1'b0};
        vecs[6]  = '{1'b1, 16'h0010, 1'b0, 1'b1, 9'h100, 8'h80, 1'b0}; // crossing
        vecs[7]  = '{1'b1, 16'h8000, 1'b0, 1'b1, 9'h101, 8'h00, 1'b0};
        vecs[8]  = '{1'b0, 16'h1111, 1'b0, 1'b0, 9'h000, 8'h00, 1'b0}; // gap
        vecs[9]  = '{1'b1, 16'h0000, 1'b0, 1'b1, 9'h102, 8'h80, 1'b0};
        vecs[10] = '{1'b1, 16'h7FFF, 1'b0, 1'b1, 9'h103, 8'hFF, 1'b0};
        vecs[11] = '{1'b1, 16'hC123, 1'b0, 1'b1, 9'h104, 8'h41, 1'b0};

        apply_reset();

        for (int unsigned i = 0; i < 12; i++) begin
            step(vecs[i].stb, vecs[i].smp, vecs[i].idle);
            check($sformatf("vec%0d.we", i), 32'(write_enable), 32'(vecs[i].exp_we));
            check($sformatf("vec%0d.ri", i), 32'(read_index), 32'(vecs[i].exp_ri));
            if (vecs[i].exp_we) begin
                check($sformatf("vec%0d.addr", i), 32'(write_address), 32'(vecs[i].exp_addr));
                check($sformatf("vec%0d.data", i), 32'(write_sample), 32'(vecs[i].exp_data));
            end
        end

        // Rest of the window with strobes on every cycle: indices 5..255.
        for (int unsigned i = 5; i < 256; i++) begin
            s = {1'b0, 7'(i), 8'h00};
            d = {1'b1, 7'(i)};
            step(1'b1, s, 1'b0);
            check_write($sformatf("b2b%0d", i), {1'b1, 8'(i)}, d);
        end

        // Window full: strobes with idle low write nothing, buffer not handed over.
        for (int unsigned i = 0; i < 50; i++) begin
            step(1'b1, (i % 2 == 0) ? 16'hF000 : 16'h0100, 1'b0);
            check($sformatf("wait%0d.we", i), 32'(write_enable), 32'd0);
        end
        check("wait.ri", 32'(read_index), 32'd0);

        step(1'b0, 16'h0000, 1'b1);
        check("handoff.ri", 32'(read_index), 32'd1);
        check("handoff.we", 32'(write_enable), 32'd0);

        // New window goes to the lower half.
        step(1'b1, 16'hFFFF, 1'b0);
        check("arm2.we", 32'(write_enable), 32'd0);
        step(1'b1, 16'h1234, 1'b0);
        check_write("cross2", 9'h000, 8'h92);
        for (int unsigned i = 1; i < 256; i++) begin
            step(1'b1, 16'h0000, 1'b0);
            check_write($sformatf("win2_%0d", i), {1'b0, 8'(i)}, 8'h80);
        end

        // Strobe coinciding with idle in WAIT: toggles, but is not a trigger.
        step(1'b1, 16'h8000, 1'b0);
        check("wait2.we", 32'(write_enable), 32'd0);
        step(1'b1, 16'h0001, 1'b1);
        check("simul.we", 32'(write_enable), 32'd0);
        check("simul.ri", 32'(read_index), 32'd0);
        step(1'b1, 16'h0002, 1'b0);
        check("simul.next.we", 32'(write_enable), 32'd0);

        // Reset after 100 written samples, last one negative.
        step(1'b1, 16'hFFFF, 1'b0);
        step(1'b1, 16'h4000, 1'b0);
        check_write("cross3", 9'h100, 8'hC0);
        for (int unsigned i = 1; i < 100; i++) begin
            step(1'b1, (i == 99) ? 16'hC000 : 16'h4000, 1'b0);
        end
        check_write("pre_rst", 9'h163, 8'h40);
        apply_reset();

        step(1'b1, 16'h0100, 1'b0);
        check("postrst0.we", 32'(write_enable), 32'd0);
        step(1'b1, 16'h8000, 1'b0);
        check("postrst1.we", 32'(write_enable), 32'd0);
        step(1'b1, 16'h0100, 1'b0);
        check_write("postrst2", 9'h100, 8'h81);
        step(1'b0, 16'h0000, 1'b0);
        check("postrst3.we", 32'(write_enable), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
